// File: rtl/led_fader.sv
// LED fader: per-channel PWM with a linear brightness decay ("comet tail").
// Optional GAMMA_EN squares brightness before the PWM compare.
module led_fader #(
  parameter int NLEDS        = 8,
  parameter int PWM_BITS     = 8,
  parameter int DECAY_PERIOD = 1000,
  parameter int DECAY_STEP   = 32
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [NLEDS-1:0] i_led,
  output logic [NLEDS-1:0] o_led,
  output logic             o_active
);

  localparam int DW =
    (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
  localparam logic [PWM_BITS-1:0] MAX  = '1;
  localparam logic [PWM_BITS-1:0] STEP =
    PWM_BITS'(DECAY_STEP);
  localparam logic [DW-1:0] DLAST = DW'(DECAY_PERIOD - 1);

  logic [NLEDS-1:0][PWM_BITS-1:0] r_bri;
  logic [NLEDS-1:0][PWM_BITS-1:0] w_level;
  logic [PWM_BITS-1:0]            r_pwm_cnt;
  logic [DW-1:0]                  r_decay_cnt;
  logic [NLEDS-1:0]               r_led;
  logic                           r_active;
  logic                           w_stb;

  assign w_stb = (r_decay_cnt == DLAST);

`ifdef GAMMA_EN
  logic [NLEDS-1:0][2*PWM_BITS-1:0] w_sq;

  // Keep the upper half of the square: level = b*b / 2**PWM_BITS.
  always_comb begin
    w_sq    = '0;
    w_level = '0;
    for (int k = 0; k < NLEDS; k++) begin
      w_sq[k] = {{PWM_BITS{1'b0}}, r_bri[k]} *
                {{PWM_BITS{1'b0}}, r_bri[k]};
      w_level[k] = w_sq[k][2*PWM_BITS-1:PWM_BITS];
    end
  end
`else
  assign w_level = r_bri;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_bri       <= '0;
      r_pwm_cnt   <= '0;
      r_decay_cnt <= '0;
      r_led       <= '0;
      r_active    <= 1'b0;
    end else begin
      r_pwm_cnt   <= r_pwm_cnt + 1'b1;
      r_decay_cnt <= w_stb ? '0 : r_decay_cnt + 1'b1;
      r_active    <= |r_bri;
      for (int k = 0; k < NLEDS; k++) begin
        r_led[k] <= (r_bri[k] == MAX) ||
                    (r_pwm_cnt < w_level[k]);
        // A set input beats a coincident decay strobe.
        if (i_led[k]) begin
          r_bri[k] <= MAX;
        end else if (w_stb) begin
          r_bri[k] <= (r_bri[k] < STEP) ? '0
                    : r_bri[k] - STEP;
        end
      end
    end
  end

  assign o_led    = r_led;
  assign o_active = r_active;

endmodule
